// File: rtl/key_pkg.sv
// Constants shared by the key_press producer and the speed/pause status machine.
package key_pkg;

  localparam int KEY_UP               = 0;
  localparam int KEY_DOWN             = 1;
  localparam int KEY_CENTER           = 2;
  localparam int N_KEYS_DEF           = 3;
  localparam int DEBOUNCE_20MS_100MHZ = 2000000;

  // Status encodings seen by the consumer of the key_press bus.
  typedef enum logic [1:0] {
    SPD_LOW   = 2'd0,
    SPD_MID   = 2'd1,
    SPD_HIGH  = 2'd2,
    SPD_PAUSE = 2'd3
  } spd_e;

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: two-flop synchroniser, stability counter, debounced level
// and a single-cycle press pulse.
module key_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic key_level,
  output logic key_press
);

  localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_level_nxt;

  always_comb begin
    w_cnt_nxt   = '0;
    w_level_nxt = r_level;
    if (r_s2 != r_level) begin
      if (r_cnt == CNT_MAX) begin
        w_level_nxt = r_s2;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values;
  // this is what makes r_s1 -> r_s2 a real two-stage synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_s1    <= btn_raw;
      r_s2    <= r_s1;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      // Pulse lands in the same cycle the new level first becomes visible.
      r_press <= w_level_nxt & ~r_level;
    end
  end

  assign key_level = r_level;
  assign key_press = r_press;

endmodule

// File: rtl/key_press_gen.sv
// Debounces the board buttons and emits one key_press pulse per accepted press;
// channels are independent so several bits may pulse together.
module key_press_gen
  import key_pkg::*;
#(
  parameter int N_KEYS          = N_KEYS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_100MHZ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] btn_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw[g]),
      .key_level(key_level[g]),
      .key_press(key_press[g])
    );
  end

endmodule

// File: tb/tb_key_press_gen.sv
// Self-checking bench for key_press_gen with a short debounce window and a
// cycle-level behavioural model of the debounce rules.
module tb_key_press_gen;

  localparam int NK = 3;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] btn_raw = '0;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: two-cycle delayed view of the button, accepted level,
  // length of the current run of disagreement, and the expected pulse.
  logic [NK-1:0] m_d1 = '0, m_d2 = '0, m_lvl = '0, m_prs = '0;
  int            m_run [NK];

  key_press_gen #(.N_KEYS(NK), .DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .key_level(key_level),
    .key_press(key_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_prs = '0;
    for (int k = 0; k < NK; k++) m_run[k] = 0;
  endtask

  // A level is accepted once the delayed button has disagreed with it for D
  // consecutive edges; a 0->1 acceptance produces one pulse.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < NK; k++) begin
        m_prs[k] = 1'b0;
        if (m_d2[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == D) begin
            m_lvl[k] = m_d2[k];
            m_run[k] = 0;
            m_prs[k] = m_lvl[k];
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = btn_raw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("key_level", 32'(key_level), 32'(m_lvl));
    check("key_press", 32'(key_press), 32'(m_prs));
    @(negedge clk);
  endtask

  // Runs n cycles and returns how many cycles key_press equalled pattern.
  task automatic run_count(input int n, input logic [NK-1:0] pattern, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (key_press == pattern) cnt++;
    end
  endtask

  // Bounded wait for any pulse after rst release; returns edge index or 0.
  task automatic latency_after_release(output int first);
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (key_press != '0 && first == 0) first = i;
    end
  endtask

  initial begin
    int c;
    int lat;
    model_reset();

    // Reset held with all buttons pressed.
    btn_raw = 3'b111;
    @(negedge clk);
    for (int i = 0; i < 4; i++) tick();
    check("rst_level_zero", 32'(key_level), 32'd0);

    // Release reset: one pulse on all keys, 6 edges later, one cycle wide.
    rst = 1'b0;
    latency_after_release(lat);
    check("rst_release_latency", 32'(lat), 32'd6);

    btn_raw = '0;
    run_count(12, 3'b000, c);

    // Clean press on BTNU held 20 cycles.
    btn_raw = 3'b001;
    run_count(20, 3'b001, c);
    check("clean_press_pulses", 32'(c), 32'd1);
    check("clean_press_held", 32'(key_level), 32'd1);
    btn_raw = '0;
    run_count(12, 3'b000, c);

    // Bounce on BTNC, then held.
    for (int r = 0; r < 4; r++) begin
      btn_raw[2] = ~r[0];
      run_count(2, 3'b100, c);
      check("bounce_no_pulse", 32'(c), 32'd0);
    end
    btn_raw[2] = 1'b1;
    run_count(12, 3'b100, c);
    check("bounce_final_pulse", 32'(c), 32'd1);

    // Release: no pulse, then press again for a new pulse.
    btn_raw = '0;
    run_count(12, 3'b100, c);
    check("release_no_pulse", 32'(c), 32'd0);
    check("release_level", 32'(key_level), 32'd0);
    btn_raw = 3'b100;
    run_count(12, 3'b100, c);
    check("repress_pulse", 32'(c), 32'd1);
    btn_raw = '0;
    run_count(12, 3'b000, c);

    // Simultaneous press of BTNU and BTNC.
    btn_raw = 3'b101;
    run_count(12, 3'b101, c);
    check("simultaneous_pulse", 32'(c), 32'd1);
    btn_raw = '0;
    run_count(12, 3'b000, c);

    // Reset mid-count, asserted between edges.
    btn_raw = 3'b111;
    for (int i = 0; i < 3; i++) tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_level", 32'(key_level), 32'd0);
    check("async_rst_press", 32'(key_press), 32'd0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    latency_after_release(lat);
    check("midrst_release_latency", 32'(lat), 32'd6);

    // Randomised segments: each button pattern held for 1..8 cycles.
    for (int s = 0; s < 150; s++) begin
      btn_raw = NK'($urandom_range(0, (1 << NK) - 1));
      for (int i = $urandom_range(1, 8); i > 0; i--) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
